// File: rtl/fp_mac_pkg.sv
// Minifloat format helpers shared by the MAC processing element and its adder.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package fp_mac_pkg;

    localparam int EXP_W_DEF  = 3;
    localparam int FRAC_W_DEF = 4;

    // Exponent bias for an exp_w-bit exponent field.
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Largest finite biased exponent.
    function automatic int fp_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    localparam int BIAS    = fp_bias(EXP_W_DEF);
    localparam int EXP_MAX = fp_exp_max(EXP_W_DEF);

    // Word layout is {sign, exp, frac}; words are passed zero-extended to 32 bits.
    function automatic logic fp_sign(input logic [31:0] word, input int exp_w, input int frac_w);
        return ((word >> (exp_w + frac_w)) & 32'd1) != 32'd0;
    endfunction

    function automatic logic [31:0] fp_exp(input logic [31:0] word, input int exp_w, input int frac_w);
        return (word >> frac_w) & ((32'd1 << exp_w) - 32'd1);
    endfunction

    function automatic logic [31:0] fp_frac(input logic [31:0] word, input int frac_w);
        return word & ((32'd1 << frac_w) - 32'd1);
    endfunction

    // A zero exponent encodes zero regardless of the fraction bits.
    function automatic logic fp_is_zero(input logic [31:0] word, input int exp_w, input int frac_w);
        return fp_exp(word, exp_w, frac_w) == 32'd0;
    endfunction

endpackage

// File: rtl/fp_add_norm.sv
// Minifloat adder: align by right shift, add/subtract magnitudes, renormalise, saturate/flush.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module fp_add_norm
    import fp_mac_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    localparam int W     = 1 + EXP_W + FRAC_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum
);

    localparam int MW     = FRAC_W + 1;
    localparam int EMAX_P = fp_exp_max(EXP_W);

    logic              sx, sy, zx, zy;
    logic [EXP_W-1:0]  ex, ey;
    logic [FRAC_W-1:0] fx, fy;

    assign sx = fp_sign(32'(x), EXP_W, FRAC_W);
    assign sy = fp_sign(32'(y), EXP_W, FRAC_W);
    assign ex = EXP_W'(fp_exp(32'(x), EXP_W, FRAC_W));
    assign ey = EXP_W'(fp_exp(32'(y), EXP_W, FRAC_W));
    assign fx = FRAC_W'(fp_frac(32'(x), FRAC_W));
    assign fy = FRAC_W'(fp_frac(32'(y), FRAC_W));
    assign zx = fp_is_zero(32'(x), EXP_W, FRAC_W);
    assign zy = fp_is_zero(32'(y), EXP_W, FRAC_W);

    logic              x_big, s_big;
    logic [EXP_W-1:0]  e_big, e_dif;
    logic [MW-1:0]     m_big, m_sml, m_aln, m_dif;
    logic [MW:0]       m_tot;
    int                lead, nshift, e_res;

    // Order operands by magnitude, align the smaller one, then add or subtract and renormalise.
    always_comb begin
        x_big = (ex > ey) || ((ex == ey) && (fx >= fy));
        s_big = x_big ? sx : sy;
        e_big = x_big ? ex : ey;
        e_dif = x_big ? (ex - ey) : (ey - ex);
        m_big = x_big ? {1'b1, fx} : {1'b1, fy};
        m_sml = x_big ? {1'b1, fy} : {1'b1, fx};
        m_aln = m_sml >> e_dif;
        m_tot = {1'b0, m_big} + {1'b0, m_aln};
        m_dif = m_big - m_aln;
        lead  = 0;
        for (int i = 0; i < MW; i++) begin
            if (m_dif[i]) lead = i;
        end
        nshift = MW - 1 - lead;
        e_res  = 0;
        sum    = '0;
        if (zx) begin
            sum = y;
        end else if (zy) begin
            sum = x;
        end else if (sx == sy) begin
            // Magnitude carry bumps the exponent by one; overflow clamps to max finite.
            e_res = int'(e_big) + (m_tot[MW] ? 1 : 0);
            if (e_res > EMAX_P)
                sum = {s_big, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
            else
                sum = {s_big, EXP_W'(e_res), m_tot[MW] ? FRAC_W'(m_tot >> 1) : FRAC_W'(m_tot)};
        end else if (m_dif != '0) begin
            // Exact cancellation leaves sum at +0; too-small results flush to +0.
            e_res = int'(e_big) - nshift;
            if (e_res >= 1)
                sum = {s_big, EXP_W'(e_res), FRAC_W'(m_dif << nshift)};
        end
    end

endmodule

// File: rtl/fp_mac_pe.sv
// Systolic minifloat MAC PE: registered multiply, registered accumulate, operands forwarded east/south.
// Latency: operands forwarded after 1 cycle; accumulator and acc_valid update 2 cycles after acceptance.
// Backpressure: none; in_valid qualifies each term and bubbles simply hold the accumulator.
module fp_mac_pe
    import fp_mac_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    localparam int W     = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_start,
    input  logic         in_last,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic         pass_valid,
    output logic         pass_start,
    output logic         pass_last,
    output logic [W-1:0] acc_out,
    output logic         acc_valid
);

    localparam int BIAS_P = fp_bias(EXP_W);
    localparam int EMAX_P = fp_exp_max(EXP_W);
    localparam int MW     = FRAC_W + 1;
    localparam int PW     = 2 * MW;

    logic              sa, sb, za, zb;
    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;

    assign sa = fp_sign(32'(a_in), EXP_W, FRAC_W);
    assign sb = fp_sign(32'(b_in), EXP_W, FRAC_W);
    assign ea = EXP_W'(fp_exp(32'(a_in), EXP_W, FRAC_W));
    assign eb = EXP_W'(fp_exp(32'(b_in), EXP_W, FRAC_W));
    assign fa = FRAC_W'(fp_frac(32'(a_in), FRAC_W));
    assign fb = FRAC_W'(fp_frac(32'(b_in), FRAC_W));
    assign za = fp_is_zero(32'(a_in), EXP_W, FRAC_W);
    assign zb = fp_is_zero(32'(b_in), EXP_W, FRAC_W);

    logic [PW-1:0] mprod, mnorm;
    logic          p_carry;
    int            p_exp;
    logic [W-1:0]  prod_nxt;

    // Multiply hidden-1 mantissas, normalise by at most one place, truncate, then saturate or flush.
    always_comb begin
        mprod    = PW'({1'b1, fa}) * PW'({1'b1, fb});
        p_carry  = mprod[PW-1];
        mnorm    = p_carry ? (mprod >> MW) : (mprod >> FRAC_W);
        p_exp    = int'(ea) + int'(eb) - BIAS_P + (p_carry ? 1 : 0);
        prod_nxt = '0;
        if (za || zb)
            prod_nxt = '0;
        else if (p_exp > EMAX_P)
            prod_nxt = {sa ^ sb, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
        else if (p_exp < 1)
            prod_nxt = '0;
        else
            prod_nxt = {sa ^ sb, EXP_W'(p_exp), FRAC_W'(mnorm)};
    end

    logic         s1_vld, s1_start, s1_last;
    logic [W-1:0] s1_prod, acc, add_sum, acc_nxt;

    fp_add_norm #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_add (
        .x   (acc),
        .y   (s1_prod),
        .sum (add_sum)
    );

    // A start term restarts the running sum from its own product.
    assign acc_nxt = s1_start ? s1_prod : add_sum;

    // Forward operands and framing to neighbours every cycle, valid or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out      <= '0;
            b_out      <= '0;
            pass_valid <= 1'b0;
            pass_start <= 1'b0;
            pass_last  <= 1'b0;
        end else begin
            a_out      <= a_in;
            b_out      <= b_in;
            pass_valid <= in_valid;
            pass_start <= in_start;
            pass_last  <= in_last;
        end
    end

    // Product stage, then accumulate on valid terms and publish on last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_start  <= 1'b0;
            s1_last   <= 1'b0;
            s1_prod   <= '0;
            acc       <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
        end else begin
            s1_vld    <= in_valid;
            s1_start  <= in_start;
            s1_last   <= in_last;
            s1_prod   <= prod_nxt;
            acc_valid <= 1'b0;
            if (s1_vld) begin
                acc <= acc_nxt;
                if (s1_last) begin
                    acc_out   <= acc_nxt;
                    acc_valid <= 1'b1;
                end
            end
        end
    end

endmodule
